// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   arb_state_t : arbitration FSM state (CPU-owned port vs. locked debug burst)
//   dbg_req_t   : debug/loader request payload as seen by the port mux
package dmem_arb_pkg;

    localparam int unsigned DM_ADDRESS_DEF = 9;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned FUNCT3_W       = 3;

    typedef enum logic [0:0] {
        ARB_CPU,
        ARB_BURST
    } arb_state_t;

    // Sized to the default bus widths of the data memory.
    typedef struct packed {
        logic                      we;
        logic                      lock;
        logic [DM_ADDRESS_DEF-1:0] a;
        logic [DATA_W_DEF-1:0]     wd;
        logic [FUNCT3_W-1:0]       Funct3;
    } dbg_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the data-memory arbiter.
//   cpu_* : MEM-stage requester (request fields in, cpu_rd/cpu_stall out)
//   dbg_* : debug/loader requester (request fields in, gnt/rvalid/rdata out)
//   mem_* : data-memory port (mem_rd is combinational read data back)
// slave  : arbiter view.  master : requesters + memory view.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = DM_ADDRESS_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF
);

    logic                    cpu_MemRead;
    logic                    cpu_MemWrite;
    logic [DM_ADDRESS-1:0]   cpu_a;
    logic [DATA_W-1:0]       cpu_wd;
    logic [FUNCT3_W-1:0]     cpu_Funct3;
    logic [DATA_W-1:0]       cpu_rd;
    logic                    cpu_stall;

    logic                    dbg_req;
    logic                    dbg_we;
    logic                    dbg_lock;
    logic [DM_ADDRESS-1:0]   dbg_a;
    logic [DATA_W-1:0]       dbg_wd;
    logic [FUNCT3_W-1:0]     dbg_Funct3;
    logic                    dbg_gnt;
    logic                    dbg_rvalid;
    logic [DATA_W-1:0]       dbg_rdata;

    logic                    mem_MemRead;
    logic                    mem_MemWrite;
    logic [DM_ADDRESS-1:0]   mem_a;
    logic [DATA_W-1:0]       mem_wd;
    logic [FUNCT3_W-1:0]     mem_Funct3;
    logic [DATA_W-1:0]       mem_rd;

    modport slave (
        input  cpu_MemRead, cpu_MemWrite, cpu_a, cpu_wd, cpu_Funct3,
        output cpu_rd, cpu_stall,
        input  dbg_req, dbg_we, dbg_lock, dbg_a, dbg_wd, dbg_Funct3,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_MemRead, mem_MemWrite, mem_a, mem_wd, mem_Funct3,
        input  mem_rd
    );

    modport master (
        output cpu_MemRead, cpu_MemWrite, cpu_a, cpu_wd, cpu_Funct3,
        input  cpu_rd, cpu_stall,
        output dbg_req, dbg_we, dbg_lock, dbg_a, dbg_wd, dbg_Funct3,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_MemRead, mem_MemWrite, mem_a, mem_wd, mem_Funct3,
        output mem_rd
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   inc, clr   : count enable, clear (clear wins)
//   cnt        : current count, stops at MAX
//   at_max     : cnt == MAX
module sat_counter #(
    parameter int unsigned W   = 3,
    parameter int unsigned MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    assign at_max = (cnt == W'(MAX));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port.
// CPU MEM stage normally owns the port; the debug/loader port gets idle
// cycles, is forced through after STARVE_MAX lost cycles, and may lock the
// port for up to MAX_BURST consecutive beats.
//   clk, reset : clock, synchronous active-high reset
//   bus        : cpu_* / dbg_* requesters and mem_* data-memory port
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = DM_ADDRESS_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    localparam int unsigned WAIT_W  = $clog2(STARVE_MAX + 1);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    arb_state_t          state;
    arb_state_t          next_state;
    dbg_req_t            dbg_fields;

    logic                cpu_act;
    logic                gnt;
    logic                wait_inc;
    logic                wait_clr;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_at_max;
    logic                burst_inc;
    logic                burst_clr;
    logic [BURST_W-1:0]  burst_cnt;
    logic                burst_at_max;
    logic                burst_last;

    assign cpu_act = bus.cpu_MemRead | bus.cpu_MemWrite;

    // Pack the debug request fields.
    always_comb begin
        dbg_fields.we     = bus.dbg_we;
        dbg_fields.lock   = bus.dbg_lock;
        dbg_fields.a      = DM_ADDRESS_DEF'(bus.dbg_a);
        dbg_fields.wd     = DATA_W_DEF'(bus.dbg_wd);
        dbg_fields.Funct3 = bus.dbg_Funct3;
    end

    // A grant now would bring the burst count to MAX_BURST.
    assign burst_last = (burst_cnt == BURST_W'(MAX_BURST - 1));

    sat_counter #(
        .W   (WAIT_W),
        .MAX (STARVE_MAX)
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (wait_inc),
        .clr    (wait_clr),
        .cnt    (wait_cnt),
        .at_max (wait_at_max)
    );

    sat_counter #(
        .W   (BURST_W),
        .MAX (MAX_BURST)
    ) u_burst_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (burst_inc),
        .clr    (burst_clr),
        .cnt    (burst_cnt),
        .at_max (burst_at_max)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_CPU;
        end else begin
            state <= next_state;
        end
    end

    // Next state, grant and counter controls.
    always_comb begin
        next_state = state;
        gnt        = 1'b0;
        wait_inc   = 1'b0;
        wait_clr   = 1'b0;
        burst_inc  = 1'b0;
        burst_clr  = 1'b0;

        case (state)
            ARB_CPU: begin
                gnt = bus.dbg_req & (!cpu_act | wait_at_max);
                // Stop counting once saturated; clear on grant or no request.
                wait_inc = bus.dbg_req & !gnt & (wait_cnt != WAIT_W'(STARVE_MAX));
                wait_clr = !bus.dbg_req | gnt;
                if (gnt && dbg_fields.lock && !burst_last) begin
                    next_state = ARB_BURST;
                    burst_inc  = 1'b1;
                end else begin
                    burst_clr = 1'b1;
                end
            end
            ARB_BURST: begin
                gnt      = bus.dbg_req & dbg_fields.lock;
                wait_clr = 1'b1;
                if (!gnt || burst_last || burst_at_max) begin
                    next_state = ARB_CPU;
                    burst_clr  = 1'b1;
                end else begin
                    burst_inc = 1'b1;
                end
            end
            default: begin
                next_state = ARB_CPU;
                wait_clr   = 1'b1;
                burst_clr  = 1'b1;
            end
        endcase

        // No grant is ever issued in a reset cycle.
        if (reset) begin
            next_state = ARB_CPU;
            gnt        = 1'b0;
            wait_inc   = 1'b0;
            burst_inc  = 1'b0;
        end
    end

    // Port mux and stall.
    always_comb begin
        bus.dbg_gnt      = gnt;
        bus.cpu_stall    = cpu_act & gnt;
        bus.cpu_rd       = bus.mem_rd;
        bus.mem_MemRead  = bus.cpu_MemRead;
        bus.mem_MemWrite = bus.cpu_MemWrite;
        bus.mem_a        = bus.cpu_a;
        bus.mem_wd       = bus.cpu_wd;
        bus.mem_Funct3   = bus.cpu_Funct3;
        if (gnt) begin
            bus.mem_MemRead  = !dbg_fields.we;
            bus.mem_MemWrite = dbg_fields.we;
            bus.mem_a        = DM_ADDRESS'(dbg_fields.a);
            bus.mem_wd       = DATA_W'(dbg_fields.wd);
            bus.mem_Funct3   = dbg_fields.Funct3;
        end
        if (reset) begin
            bus.mem_MemRead  = 1'b0;
            bus.mem_MemWrite = 1'b0;
        end
    end

    // Debug read return, one cycle after a granted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.dbg_rvalid <= 1'b0;
            bus.dbg_rdata  <= '0;
        end else begin
            bus.dbg_rvalid <= gnt & !dbg_fields.we;
            if (gnt && !dbg_fields.we) begin
                bus.dbg_rdata <= bus.mem_rd;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single data-memory port. Requester 0 is the pipeline MEM stage, which issues an access when EX/MEM MemRead or MemWrite is set. Requester 1 is a debug/loader port that lets the bench or a loader read and write data memory while the core runs. The block sits between the EX/MEM register and `datamemory`. It grants one access per cycle, asserts a stall to freeze the pipeline while a debug access holds the port, and bounds debug starvation with a wait counter.

## Interface
Parameters:
- DM_ADDRESS, 9, data-memory address width
- DATA_W, 32, data width
- STARVE_MAX, 4, number of cycles a pending debug request may lose to the CPU before it is forced through (≥1)
- MAX_BURST, 8, maximum consecutive locked debug beats (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cpu_MemRead  in  1  MEM-stage read request
- cpu_MemWrite  in  1  MEM-stage write request
- cpu_a  in  DM_ADDRESS  MEM-stage address
- cpu_wd  in  DATA_W  MEM-stage write data
- cpu_Funct3  in  3  MEM-stage access size/sign
- cpu_rd  out  DATA_W  read data to MEM/WB (combinational from mem_rd)
- cpu_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert a bubble into MEM/WB
- dbg_req  in  1  debug access request
- dbg_we  in  1  1 = write, 0 = read
- dbg_lock  in  1  request burst ownership
- dbg_a  in  DM_ADDRESS  debug address
- dbg_wd  in  DATA_W  debug write data
- dbg_Funct3  in  3  debug access size
- dbg_gnt  out  1  access performed this cycle
- dbg_rvalid  out  1  registered read data valid
- dbg_rdata  out  DATA_W  registered read data
- mem_MemRead  out  1  to datamemory
- mem_MemWrite  out  1  to datamemory
- mem_a  out  DM_ADDRESS  to datamemory
- mem_wd  out  DATA_W  to datamemory
- mem_Funct3  out  3  to datamemory
- mem_rd  in  DATA_W  combinational read data from datamemory

## Operation
- cpu_act = cpu_MemRead | cpu_MemWrite.
- Mux: when dbg_gnt=1, mem_* carry the dbg_* fields (mem_MemWrite=dbg_we, mem_MemRead=!dbg_we). Otherwise mem_* carry the cpu_* fields unchanged.
- States (arb_state_t): ARB_CPU (reset state) and ARB_BURST.
- ARB_CPU:
  - dbg_gnt = dbg_req & (!cpu_act | wait_cnt==STARVE_MAX).
  - wait_cnt increments when dbg_req & !dbg_gnt, saturating at STARVE_MAX.
  - wait_cnt clears on dbg_gnt or when dbg_req=0.
  - On dbg_gnt & dbg_lock: go to ARB_BURST with burst_cnt=1.
- ARB_BURST:
  - dbg_gnt = dbg_req & dbg_lock. The CPU is blocked.
  - burst_cnt increments on each grant.
  - Return to ARB_CPU, with wait_cnt=0, when (a) the current cycle has no grant, or (b) a grant makes burst_cnt reach MAX_BURST.
  - After exiting, the next debug grant obeys the ARB_CPU rules.
- cpu_stall = cpu_act & dbg_gnt.
- Debug requester contract: hold all dbg_* stable while dbg_req=1 and dbg_gnt=0. dbg_req may drop only after a granted cycle.
- Debug read return: dbg_rdata <= mem_rd and dbg_rvalid <= 1 on the cycle after a granted read. Otherwise dbg_rvalid <= 0 and dbg_rdata holds its value.

## Timing
- Reset (synchronous) sets:
  - state=ARB_CPU, wait_cnt=0, burst_cnt=0
  - dbg_rvalid=0, dbg_rdata=0
- While reset=1, combinational outputs are forced to dbg_gnt=0, cpu_stall=0, mem_MemRead=0, mem_MemWrite=0.
- Reset asserted mid-burst aborts the burst. No grant is issued in the reset cycle.
- CPU access: zero added latency when not stalled. cpu_rd is valid in the same cycle.
- Debug access, memory idle: granted in the same cycle dbg_req rises.
- Debug access under continuous CPU traffic: granted exactly STARVE_MAX cycles after dbg_req rises.
- Debug read data: dbg_rvalid one cycle after dbg_gnt.
- Stall and grant are combinational from registered state plus inputs. There is no path from any mem_rd-derived output back into the arbitration decision.

## Structure
- Package dmem_arb_pkg holds:
  - typedef enum logic [0:0] arb_state_t {ARB_CPU, ARB_BURST}
  - a dbg_req_t struct {we, lock, a, wd, Funct3}
- One sub-module: sat_counter (parameterised width and max; inputs inc and clr; output cnt and at_max). It is instantiated twice, for wait_cnt and burst_cnt.

## Test plan
- CPU-only traffic: no dbg_req, cpu_MemWrite to addr 0x10 with data 0xDEADBEEF, then cpu_MemRead from 0x10 → cpu_rd=0xDEADBEEF, cpu_stall never set.
- Idle debug read: dbg_req with dbg_we=0, addr 0x10, CPU idle → dbg_gnt in the same cycle; next cycle dbg_rvalid=1, dbg_rdata=0xDEADBEEF.
- Starvation: cpu_MemRead high every cycle, dbg_req rises at cycle t, STARVE_MAX=4 → dbg_gnt and cpu_stall both 1 only at cycle t+4; CPU mem_* are restored at t+5.
- Locked burst: dbg_lock=1, 10 write beats to addresses 0x20.., MAX_BURST=8, CPU active → 8 consecutive grants; CPU granted in the 9th cycle; 9th debug beat granted only per the starvation rule.
- Reset mid-burst: reset asserted during beat 3 → same-cycle dbg_gnt=0, mem_MemWrite=0; after release state is ARB_CPU and dbg_rvalid=0.
- Simultaneous CPU write and debug read of the same address with wait_cnt<STARVE_MAX → CPU write wins; the debug read granted later returns the new data.
